// File: rtl/bitwise_pkg.sv
// rtl/bitwise_pkg.sv - shared op and state encodings for bitwise_unit
package bitwise_pkg;

    typedef enum logic [1:0] {
        BW_AND  = 2'b00,
        BW_OR   = 2'b01,
        BW_XOR  = 2'b10,
        BW_ANDN = 2'b11
    } bw_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } bw_state_e;

endpackage

// File: rtl/bitwise_slice.sv
// rtl/bitwise_slice.sv - combinational CHUNK-wide logic op, shared across slices
module bitwise_slice
    import bitwise_pkg::*;
#(
    parameter int CHUNK = 8
) (
    input  logic [1:0]       op_i,
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    output logic [CHUNK-1:0] c_o
);

    always_comb begin
        c_o = '0;
        case (bw_op_e'(op_i))
            BW_AND:  c_o = a_i & b_i;
            BW_OR:   c_o = a_i | b_i;
            BW_XOR:  c_o = a_i ^ b_i;
            BW_ANDN: c_o = a_i & ~b_i;
            default: c_o = '0;
        endcase
    end

endmodule

// File: rtl/bitwise_unit.sv
// rtl/bitwise_unit.sv - slice-serial bitwise ALU with valid/ready handshakes
// Optional parity output enabled by defining BITWISE_UNIT_PARITY_EN.
module bitwise_unit
    import bitwise_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] c_o,
    output logic             zero_o
`ifdef BITWISE_UNIT_PARITY_EN
    ,
    output logic             parity_o
`endif
);

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    generate
        if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_chunk
            $error("bitwise_unit: WIDTH must be a positive multiple of CHUNK");
        end
    endgenerate

    bw_state_e        r_state;
    bw_state_e        w_state_next;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    bw_op_e           r_op;
    logic [WIDTH-1:0] r_c;
    logic [CHUNK-1:0] w_slice;
    logic             w_accept;
    logic             w_last;
    int               w_base;

    assign w_base   = int'(r_cnt) * CHUNK;
    assign w_accept = (r_state == ST_IDLE) && valid_i;
    assign w_last   = (r_cnt == LAST);

    bitwise_slice #(
        .CHUNK (CHUNK)
    ) u_slice (
        .op_i (r_op),
        .a_i  (r_a[w_base +: CHUNK]),
        .b_i  (r_b[w_base +: CHUNK]),
        .c_o  (w_slice)
    );

    always_comb begin
        w_state_next = r_state;
        ready_o      = 1'b0;
        valid_o      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                ready_o = 1'b1;
                if (valid_i) w_state_next = ST_BUSY;
            end
            ST_BUSY: begin
                if (w_last) w_state_next = ST_DONE;
            end
            ST_DONE: begin
                valid_o = 1'b1;
                if (ready_i) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= BW_AND;
            r_c     <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_a   <= a_i;
                r_b   <= b_i;
                r_op  <= bw_op_e'(op_i);
                r_cnt <= '0;
                r_c   <= '0;
            end else if (r_state == ST_BUSY) begin
                r_c[w_base +: CHUNK] <= w_slice;
                // hold on the last slice so the counter never wraps
                if (!w_last) r_cnt <= r_cnt + 1'b1;
            end
        end
    end

`ifdef BITWISE_UNIT_PARITY_EN
    logic r_parity;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_parity <= 1'b0;
        end else if (w_accept) begin
            r_parity <= 1'b0;
        end else if (r_state == ST_BUSY) begin
            r_parity <= r_parity ^ (^w_slice);
        end
    end

    assign parity_o = r_parity;
`endif

    assign c_o    = r_c;
    assign zero_o = (r_c == '0);

endmodule

// File: doc/bitwise_unit.md
BITWISE_UNIT -- requirements
Module: bitwise_unit

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits.
REQ-002 Parameter CHUNK, default 8, slice width processed per cycle; WIDTH SHALL be an integer multiple of CHUNK (elaboration error otherwise).
REQ-003 clk_i  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_i  input  1  reset, synchronous, active-high.
REQ-005 valid_i  input  1  request valid.
REQ-006 ready_o  output  1  unit accepts a request this cycle.
REQ-007 op_i  input  2  operation: 00 AND, 01 OR, 10 XOR, 11 ANDN (a & ~b).
REQ-008 a_i, b_i  input  WIDTH  operands.
REQ-009 valid_o  output  1  result valid.
REQ-010 ready_i  input  1  consumer accepts result.
REQ-011 c_o  output  WIDTH  registered result.
REQ-012 zero_o  output  1  1 when c_o == 0; meaningful only while valid_o=1.
REQ-013 parity_o  output  1  XOR-reduction of c_o; present only with BITWISE_UNIT_PARITY_EN.

Function
REQ-014 The FSM SHALL have states IDLE, BUSY and DONE, with N = WIDTH/CHUNK.
REQ-015 IDLE: ready_o=1 and valid_o=0; on valid_i&ready_o, latch a_i, b_i and op_i, clear slice counter, go BUSY.
REQ-016 BUSY: ready_o=0; each cycle write slice cnt (bits cnt*CHUNK+CHUNK-1 : cnt*CHUNK) of the result register, LSB slice first, then cnt++.
REQ-017 BUSY SHALL go to DONE in the cycle slice N-1 is written; the counter never wraps past N-1.
REQ-018 N=1 (CHUNK==WIDTH) SHALL take exactly one BUSY cycle.
REQ-019 Latency: valid_o SHALL rise N+1 cycles after the accepting edge.
REQ-020 DONE: valid_o=1, ready_o=0; c_o, zero_o and parity_o SHALL stay stable until valid_o&ready_i, then go IDLE.
REQ-021 There is no same-cycle result-drain/new-accept; throughput is one request per N+2 cycles minimum.
REQ-022 op_i, a_i and b_i SHALL be ignored outside the accepting cycle, and valid_i SHALL be ignored in BUSY/DONE.
REQ-023 Unwritten result bits SHALL NOT be visible on c_o as valid data; valid_o gates use.

Reset
REQ-024 rst_i=1 SHALL force state IDLE, counter 0, c_o=0, valid_o=0, ready_o=1 after the edge.
REQ-025 Reset in BUSY or DONE SHALL abort the operation and discard the result with no valid_o pulse.
REQ-026 rst_i SHALL have priority over a simultaneous valid_i or ready_i.

Configuration
REQ-027 With BITWISE_UNIT_PARITY_EN defined, parity_o exists and is computed incrementally per slice (running XOR cleared on accept).
REQ-028 Without BITWISE_UNIT_PARITY_EN, port parity_o and its register SHALL be absent; all other behaviour is identical.

Structure
REQ-029 Shared package bitwise_pkg SHALL hold op encoding typedef bw_op_e (AND/OR/XOR/ANDN) and state typedef bw_state_e.
REQ-030 Sub-module bitwise_slice (combinational, CHUNK-wide, op-selected) SHALL be instantiated once and time-multiplexed across slices.

Verification (WIDTH=32, CHUNK=8)
REQ-031 AND: a=F0F0_1234, b=0FF0_FFFF -> c_o=00F0_1234, zero_o=0, valid_o rising 5 cycles after accept.
REQ-032 XOR: a=b=DEAD_BEEF -> c_o=0, zero_o=1, parity_o=0 (macro on).
REQ-033 ANDN: a=FFFF_FFFF, b=0000_00FF -> c_o=FFFF_FF00; OR a=1,b=0 -> c_o=1, parity_o=1.
REQ-034 Backpressure: ready_i=0 for 5 cycles in DONE with valid_i pulsing and a_i changing -> c_o stable, ready_o=0, no new accept; drain then ready_o=1 next cycle.
REQ-035 Reset while writing slice 2 -> next cycle valid_o=0, ready_o=1, c_o=0; a following request completes normally.
REQ-036 CHUNK=WIDTH=32 build: any op -> valid_o 2 cycles after accept.
